// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream
//   Streaming 1-D max-pool with optional ReLU. Each group of P consecutive
//   accepted samples is reduced to its signed maximum. When RELU is set, that
//   maximum is clamped at zero before it is emitted. Both sides use
//   valid/ready handshakes. The output side is a one-entry register.
//
// Parameters
//   T    : sample width, two's-complement signed
//   P    : pool window length (>= 1)
//   RELU : 1 = clamp negative results to zero, 0 = pass through
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   x_data   : input sample
//   x_valid  : upstream offers x_data
//   x_ready  : sample accepted this cycle when x_valid is also high
//   y_data   : pooled result
//   y_valid  : y_data holds an undelivered result
//   y_ready  : downstream accepts y_data this cycle
module relu_maxpool_stream #(
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  // P == 1 still needs a 1-bit counter. It simply stays at zero.
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [T-1:0] acc_q, acc_d;
  logic [T-1:0]        y_data_q, y_data_d;
  logic                y_valid_q, y_valid_d;

  logic                in_fire, out_fire, win_done;
  logic signed [T-1:0] x_s, pooled, rect;

  assign x_s = $signed(x_data);

  // The output register frees up on the same edge it is drained. The
  // completing sample therefore only waits while a result is actually stuck.
  assign x_ready  = (cnt_q != LAST) || !y_valid_q || y_ready;
  assign in_fire  = x_valid && x_ready;
  assign out_fire = y_valid_q && y_ready;
  assign win_done = in_fire && (cnt_q == LAST);

  // The first sample of a window replaces the accumulator, so samples from
  // earlier windows never leak in. With P == 1 this is always the x_data path.
  always_comb begin
    if (cnt_q == '0) begin
      pooled = x_s;
    end else begin
      pooled = (acc_q > x_s) ? acc_q : x_s;
    end
  end

  assign rect = ((RELU != 0) && pooled[T-1]) ? '0 : pooled;

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    if (out_fire) begin
      y_valid_d = 1'b0;
    end
    // A completing window overrides the clear above, giving full-rate
    // operation with no bubble.
    if (in_fire) begin
      acc_d = pooled;
      if (win_done) begin
        cnt_d     = '0;
        y_data_d  = rect;
        y_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// tb_relu_maxpool_stream
//   Directed bench for relu_maxpool_stream. It uses four instances:
//     0: P=2 RELU=1   1: P=3 RELU=0   2: P=4 RELU=1   3: P=1 RELU=1
//   Inputs are driven on the falling edge. A monitor logs every input and
//   output transfer on the rising edge.
module tb_relu_maxpool_stream;

  localparam int T = 16;
  localparam int NRAND = 2340;

  logic         clk;
  logic         rst;
  logic [T-1:0] xd [4];
  logic         xv [4];
  logic         xr [4];
  logic [T-1:0] yd [4];
  logic         yv [4];
  logic         yr [4];

  logic [T-1:0] inq  [4][$];
  logic [T-1:0] outq [4][$];
  int           vcyc [4];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  relu_maxpool_stream #(.T(T), .P(2), .RELU(1)) u_p2r1 (
    .clk(clk), .reset(rst), .x_data(xd[0]), .x_valid(xv[0]), .x_ready(xr[0]),
    .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0]));
  relu_maxpool_stream #(.T(T), .P(3), .RELU(0)) u_p3r0 (
    .clk(clk), .reset(rst), .x_data(xd[1]), .x_valid(xv[1]), .x_ready(xr[1]),
    .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1]));
  relu_maxpool_stream #(.T(T), .P(4), .RELU(1)) u_p4r1 (
    .clk(clk), .reset(rst), .x_data(xd[2]), .x_valid(xv[2]), .x_ready(xr[2]),
    .y_data(yd[2]), .y_valid(yv[2]), .y_ready(yr[2]));
  relu_maxpool_stream #(.T(T), .P(1), .RELU(1)) u_p1r1 (
    .clk(clk), .reset(rst), .x_data(xd[3]), .x_valid(xv[3]), .x_ready(xr[3]),
    .y_data(yd[3]), .y_valid(yv[3]), .y_ready(yr[3]));

  initial begin
    for (int k = 0; k < 4; k++) vcyc[k] = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (xv[k] && xr[k]) inq[k].push_back(xd[k]);
        if (yv[k] && yr[k]) outq[k].push_back(yd[k]);
        if (yv[k]) vcyc[k] = vcyc[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one sample starting at a falling edge. Return at the falling edge
  // after the accepting rising edge, with x_valid still high.
  task automatic send(input int k, input logic [T-1:0] v, output int waits);
    logic ok;
    waits = 0;
    xv[k] = 1'b1;
    xd[k] = v;
    forever begin
      ok = xr[k];
      @(negedge clk);
      if (ok) break;
      waits++;
      if (waits > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int k, input int n);
    xv[k] = 1'b0;
    xd[k] = 'x;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [T-1:0] ref_pool2(input logic [T-1:0] a, input logic [T-1:0] b);
    logic signed [T-1:0] m;
    m = ($signed(a) > $signed(b)) ? $signed(a) : $signed(b);
    return (m < 0) ? '0 : m;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ob;
    int vb;
    int ib;
    int cyc;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      xv[k] = 1'b0;
      xd[k] = 'x;
      yr[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_yvalid%0d", k), {31'd0, yv[k]}, 32'd0);
      check($sformatf("rst_ydata%0d", k), {16'd0, yd[k]}, 32'd0);
      check($sformatf("rst_xready%0d", k), {31'd0, xr[k]}, 32'd1);
    end

    // P=2 RELU=1, y_ready held high
    ob = outq[0].size();
    vb = vcyc[0];
    send(0, 16'd3, w);
    send(0, 16'd7, w);
    check("p2_first_valid", {31'd0, yv[0]}, 32'd1);
    check("p2_first_data", {16'd0, yd[0]}, 32'd7);
    send(0, 16'hFFFB, w);
    check("p2_valid_drop", {31'd0, yv[0]}, 32'd0);
    send(0, 16'hFFFE, w);
    send(0, 16'h7FFF, w);
    send(0, 16'h8000, w);
    idle(0, 3);
    check("p2_nout", outq[0].size() - ob, 32'd3);
    if (outq[0].size() - ob == 3) begin
      check("p2_out0", {16'd0, outq[0][ob]}, 32'd7);
      check("p2_out1", {16'd0, outq[0][ob+1]}, 32'd0);
      check("p2_out2", {16'd0, outq[0][ob+2]}, 32'h7FFF);
    end
    check("p2_valid_cycles", vcyc[0] - vb, 32'd3);

    // P=3 RELU=0, including the most negative value
    ob = outq[1].size();
    send(1, 16'hFFF7, w);
    send(1, 16'hFFFC, w);
    send(1, 16'hFFFA, w);
    send(1, 16'h8000, w);
    send(1, 16'h8000, w);
    send(1, 16'h8000, w);
    idle(1, 3);
    check("p3_nout", outq[1].size() - ob, 32'd2);
    if (outq[1].size() - ob == 2) begin
      check("p3_out0", {16'd0, outq[1][ob]}, 32'hFFFC);
      check("p3_out1", {16'd0, outq[1][ob+1]}, 32'h8000);
    end

    // Backpressure, P=2
    ob = outq[0].size();
    send(0, 16'd1, w);
    send(0, 16'd5, w);
    yr[0] = 1'b0;
    send(0, 16'd2, w);
    check("bp_third_accept_wait", w, 32'd0);
    xd[0] = 16'd9;
    xv[0] = 1'b1;
    #1;
    check("bp_xready_low", {31'd0, xr[0]}, 32'd0);
    repeat (3) @(negedge clk);
    check("bp_xready_held", {31'd0, xr[0]}, 32'd0);
    check("bp_ydata_stable", {16'd0, yd[0]}, 32'd5);
    check("bp_yvalid_held", {31'd0, yv[0]}, 32'd1);
    yr[0] = 1'b1;
    #1;
    check("bp_xready_comb", {31'd0, xr[0]}, 32'd1);
    @(negedge clk);
    xv[0] = 1'b0;
    xd[0] = 'x;
    check("bp_new_valid", {31'd0, yv[0]}, 32'd1);
    check("bp_new_data", {16'd0, yd[0]}, 32'd9);
    check("bp_first_xfer", outq[0].size() - ob, 32'd1);
    idle(0, 2);
    check("bp_nout", outq[0].size() - ob, 32'd2);
    if (outq[0].size() - ob == 2) begin
      check("bp_out0", {16'd0, outq[0][ob]}, 32'd5);
      check("bp_out1", {16'd0, outq[0][ob+1]}, 32'd9);
    end

    // Reset mid-window, P=4
    ob = outq[2].size();
    send(2, 16'd10, w);
    send(2, 16'd20, w);
    xv[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_yvalid", {31'd0, yv[2]}, 32'd0);
    check("rstmid_xready", {31'd0, xr[2]}, 32'd1);
    ob = outq[2].size();
    send(2, 16'd1, w);
    send(2, 16'd2, w);
    send(2, 16'd3, w);
    send(2, 16'd4, w);
    idle(2, 3);
    check("rstmid_nout", outq[2].size() - ob, 32'd1);
    if (outq[2].size() - ob == 1) check("rstmid_out", {16'd0, outq[2][ob]}, 32'd4);

    // P=1 RELU=1 at full rate
    ob = outq[3].size();
    send(3, 16'hFFFF, w);
    check("p1_valid0", {31'd0, yv[3]}, 32'd1);
    check("p1_data0", {16'd0, yd[3]}, 32'd0);
    send(3, 16'd5, w);
    check("p1_fullrate_wait", w, 32'd0);
    check("p1_data1", {16'd0, yd[3]}, 32'd5);
    idle(3, 2);
    check("p1_nout", outq[3].size() - ob, 32'd2);

    // Randomized handshakes on P=2 against the reference pool
    ib = inq[0].size();
    ob = outq[0].size();
    cyc = 0;
    while (!((inq[0].size() - ib == 2 * NRAND) && (outq[0].size() - ob == NRAND)) && cyc < 40000) begin
      yr[0] = 1'($urandom_range(0, 1));
      if (inq[0].size() - ib < 2 * NRAND) begin
        xv[0] = 1'($urandom_range(0, 1));
        xd[0] = 16'($urandom);
      end else begin
        xv[0] = 1'b0;
        xd[0] = 'x;
      end
      @(negedge clk);
      cyc++;
    end
    xv[0] = 1'b0;
    yr[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("rand_nin", inq[0].size() - ib, 2 * NRAND);
    check("rand_nout", outq[0].size() - ob, NRAND);
    if ((inq[0].size() - ib == 2 * NRAND) && (outq[0].size() - ob == NRAND)) begin
      for (int i = 0; i < NRAND; i++) begin
        check($sformatf("rand_out%0d", i), {16'd0, outq[0][ob+i]},
              {16'd0, ref_pool2(inq[0][ib+2*i], inq[0][ib+2*i+1])});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_maxpool_stream.md
# relu_maxpool_stream

Streaming ReLU and 1-D max-pool stage that sits directly downstream of the convolution network output. It consumes the network's signed T-bit `y` stream through a valid/ready handshake and reduces each group of P consecutive values to their maximum. When enabled, it clamps that maximum at zero before emitting it. It re-emits the result on an identical valid/ready stream, so it chains to any consumer that uses the same handshake.

## Interface
- `T`, 16: data width, two's-complement signed.
- `P`, 2: pool window length in samples; legal range is P ≥ 1.
- `RELU`, 1: 1 applies max(v, 0) to each pooled result; 0 passes the pooled result through unchanged.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `x_data` input T: signed input sample.
- `x_valid` input 1: upstream offers `x_data`.
- `x_ready` output 1: block accepts `x_data` this cycle.
- `y_data` output T: signed pooled (and optionally rectified) result.
- `y_valid` output 1: `y_data` holds an undelivered result.
- `y_ready` input 1: downstream accepts `y_data` this cycle.

## Operation
- Transfers:
  - An input transfer occurs on an edge where `x_valid && x_ready`.
  - An output transfer occurs on an edge where `y_valid && y_ready`.
- State:
  - Window counter `cnt`, range 0..P-1.
  - Running maximum `acc`, T bits, signed.
  - One-entry output register `{y_valid, y_data}`.
- Input transfer with `cnt == 0`: `acc <= x_data`.
- Input transfer with `0 < cnt`: `acc <= max_signed(acc, x_data)`.
- Counter: `cnt` increments on each input transfer and wraps to 0 after P-1.
- Window completion, i.e. an input transfer with `cnt == P-1`:
  - `y_data <= f(max_signed(acc, x_data))`. When P == 1 the argument is `x_data` alone.
  - `f(v)` is `(v < 0) ? 0 : v` when RELU == 1, and `v` otherwise.
  - `y_valid <= 1`.
  - `acc` value after completion is don't-care.
- Comparison:
  - Full T-bit signed compare; no widening, no saturation needed.
  - Most negative value (0x8000 at T = 16) is a legal input and a legal result when RELU == 0.
- `y_valid` clears on an output transfer unless a window completes on the same edge. In that case the new result loads and `y_valid` stays 1.
- `y_data` is held stable while `y_valid && !y_ready`.
- Samples from different windows never combine. Window alignment is defined solely by the count of accepted inputs since reset.

## Timing
- Reset values, one edge after `reset` is sampled high:
  - `cnt = 0`, `y_valid = 0`, `y_data = 0`.
  - `acc` is don't-care.
  - `x_ready` is 1 after reset.
- A `reset` asserted mid-window discards any partial window and any undelivered output. The next accepted input starts a fresh window.
- `x_ready = (cnt != P-1) || !y_valid || y_ready`:
  - Combinational from `y_ready`, `cnt` and `y_valid`; no combinational dependence on `x_valid`.
  - Non-completing samples are always accepted.
  - The completing sample stalls only while an undelivered result is blocked.
- Latency: `y_valid` rises on the edge that accepts the P-th sample of a window, so data is visible the following cycle.
- Throughput: one input per cycle sustained when `y_ready` is held high. One output per P inputs.
- Full-rate case: a completing input on the same edge as an output transfer is allowed, with no bubble.
- `x_data` is ignored when `x_valid == 0` and may be X. No X may propagate to `y_data` or `y_valid`.
- Output protocol: once `y_valid` is 1 it stays 1 until the transfer, and `y_data` does not change meanwhile.

## Test plan
- Basic pool, P=2, RELU=1, `y_ready` held 1:
  - Stimulus: inputs 3, 7, -5, -2, 0x7FFF, 0x8000.
  - Required: outputs 7, 0, 0x7FFF. `y_valid` is high for exactly one cycle after the edges accepting the 2nd, 4th and 6th inputs.
- RELU=0, P=3:
  - Stimulus: inputs -9, -4, -6, 0x8000, 0x8000, 0x8000.
  - Required: outputs -4 (0xFFFC), 0x8000.
- Backpressure, P=2:
  - Stimulus: hold `y_ready=0` after the first window completes.
  - Required: the 3rd input is accepted. `x_ready` drops while `cnt == 1` with the 4th sample pending, and `y_data` stays stable. When `y_ready` rises, the result transfers and the 4th input is accepted on that same edge.
- Randomized handshakes:
  - Stimulus: pseudo-random `x_valid` and `y_ready` (each 50%) over 2340 × P inputs, compared against a reference model.
  - Required: zero mismatches, exactly 2340 outputs, no lost or duplicated samples.
- Reset mid-window, P=4:
  - Stimulus: accept 10, 20, assert `reset` for one cycle, then accept 1, 2, 3, 4.
  - Required: single output 4; no output containing 10 or 20. `y_valid` is 0 in the cycle after reset.
- P=1, RELU=1:
  - Stimulus: inputs -1, 5.
  - Required: outputs 0, 5, one per accepted input, at full rate when `y_ready=1`.
